// File: rtl/conv_tree_deserializer.sv
// Serial-to-parallel receiver: rebuilds OUTPUTS_NUM-bit words from a one-bit
// stream framed by an ALIGN strobe on the first bit of each word.
// The stream may be paused with EN, and single bits may be dropped with BITSLIP.
module conv_tree_deserializer #(
    parameter int OUTPUTS_NUM = 4,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   SERIAL_IN,
    input  logic                   EN,
    input  logic                   ALIGN,
    input  logic                   BITSLIP,
    output logic [OUTPUTS_NUM-1:0] PAR_OUT,
    output logic                   PAR_VALID,
    output logic                   LOCKED,
    output logic                   ALIGN_ERR
);

    localparam int CW = $clog2(OUTPUTS_NUM);
    localparam logic [CW-1:0] LAST_IDX = CW'(OUTPUTS_NUM - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [OUTPUTS_NUM-1:0] shift_reg, shift_next;
    logic [OUTPUTS_NUM-1:0] par_out_reg, par_out_next;
    logic                   par_valid_reg, par_valid_next;
    logic                   align_err_reg, align_err_next;

    // Capture control. ALIGN always starts a fresh word at index 0, whether
    // it arrives on a word boundary or not, so the base becomes all-zero.
    logic                   take;
    logic                   restart;
    logic [CW-1:0]          cap_idx;
    logic [OUTPUTS_NUM-1:0] base_word;
    logic [OUTPUTS_NUM-1:0] sel;
    logic [OUTPUTS_NUM-1:0] word;

    assign restart   = EN && ALIGN;
    assign take      = EN && (ALIGN || ((state_reg == SHIFT) && !BITSLIP));
    assign cap_idx   = restart ? '0 : cnt_reg;
    assign base_word = restart ? '0 : shift_reg;

    // One-hot select of the output bit that receives the capture index.
    generate
        for (genvar gi = 0; gi < OUTPUTS_NUM; gi++) begin : g_place
            localparam logic [CW-1:0] IDX = MSB_FIRST ? CW'(OUTPUTS_NUM - 1 - gi) : CW'(gi);
            assign sel[gi] = (cap_idx == IDX);
        end
    endgenerate

    assign word = (base_word & ~sel) | (sel & {OUTPUTS_NUM{SERIAL_IN}});

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            par_out_reg   <= '0;
            par_valid_reg <= 1'b0;
            align_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shift_reg     <= shift_next;
            par_out_reg   <= par_out_next;
            par_valid_reg <= par_valid_next;
            align_err_reg <= align_err_next;
        end
    end

    // Next-state logic: capture, word completion and framing-error detection.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shift_next     = shift_reg;
        par_out_next   = par_out_reg;
        par_valid_next = 1'b0;
        align_err_next = 1'b0;

        if (EN && ALIGN && (state_reg == SHIFT) && (cnt_reg != '0)) begin
            align_err_next = 1'b1;
        end

        if (take) begin
            state_next = SHIFT;
            if (cap_idx == LAST_IDX) begin
                // Last bit of the word: publish it, and start the next word clean.
                cnt_next       = '0;
                shift_next     = '0;
                par_out_next   = word;
                par_valid_next = 1'b1;
            end else begin
                cnt_next   = cap_idx + CW'(1);
                shift_next = word;
            end
        end
    end

    assign PAR_OUT   = par_out_reg;
    assign PAR_VALID = par_valid_reg;
    assign LOCKED    = (state_reg == SHIFT);
    assign ALIGN_ERR = align_err_reg;

endmodule

// File: tb/tb_conv_tree_deserializer.sv
// Directed bench: a table of per-cycle vectors for the 4-bit MSB-first
// instance, plus a hand-written sequence for the 8-bit LSB-first instance.
module tb_conv_tree_deserializer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       SERIAL_IN = 1'b0;
    logic       EN = 1'b0;
    logic       ALIGN = 1'b0;
    logic       BITSLIP = 1'b0;
    logic [3:0] par4;
    logic       valid4, locked4, err4;
    logic [7:0] par8;
    logic       valid8, locked8, err8;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    conv_tree_deserializer #(.OUTPUTS_NUM(4), .MSB_FIRST(1'b1)) dut4 (
        .CLK(CLK), .RESET(RESET), .SERIAL_IN(SERIAL_IN), .EN(EN),
        .ALIGN(ALIGN), .BITSLIP(BITSLIP), .PAR_OUT(par4),
        .PAR_VALID(valid4), .LOCKED(locked4), .ALIGN_ERR(err4)
    );

    conv_tree_deserializer #(.OUTPUTS_NUM(8), .MSB_FIRST(1'b0)) dut8 (
        .CLK(CLK), .RESET(RESET), .SERIAL_IN(SERIAL_IN), .EN(EN),
        .ALIGN(ALIGN), .BITSLIP(BITSLIP), .PAR_OUT(par8),
        .PAR_VALID(valid8), .LOCKED(locked8), .ALIGN_ERR(err8)
    );

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       align;
        logic       slip;
        logic       sin;
        logic       valid;
        logic [3:0] par;
        logic       locked;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic en, input logic align,
                       input logic slip, input logic sin, input logic valid,
                       input logic [3:0] par, input logic locked, input logic err);
        vec_t v;
        v.rst = rst; v.en = en; v.align = align; v.slip = slip; v.sin = sin;
        v.valid = valid; v.par = par; v.locked = locked; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    // Drive one cycle of inputs; outputs are sampled 1ns after the edge.
    task automatic drive(input logic rst, input logic en, input logic align,
                         input logic slip, input logic sin);
        RESET = rst; EN = en; ALIGN = align; BITSLIP = slip; SERIAL_IN = sin;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [7:0] bits8;
        //   rst en al sl si   val par   lk er
        // Reset
        add(1, 0, 0, 0, 0,     0, 4'h0, 0, 0);
        // Word 1011 with ALIGN on the first bit
        add(0, 1, 1, 0, 1,     0, 4'h0, 1, 0);
        add(0, 1, 0, 0, 0,     0, 4'h0, 1, 0);
        add(0, 1, 0, 0, 1,     0, 4'h0, 1, 0);
        add(0, 1, 0, 0, 1,     1, 4'hB, 1, 0);
        // Back-to-back 1011 then 0110, no ALIGN
        add(0, 1, 0, 0, 1,     0, 4'hB, 1, 0);
        add(0, 1, 0, 0, 0,     0, 4'hB, 1, 0);
        add(0, 1, 0, 0, 1,     0, 4'hB, 1, 0);
        add(0, 1, 0, 0, 1,     1, 4'hB, 1, 0);
        add(0, 1, 0, 0, 0,     0, 4'hB, 1, 0);
        add(0, 1, 0, 0, 1,     0, 4'hB, 1, 0);
        add(0, 1, 0, 0, 1,     0, 4'hB, 1, 0);
        add(0, 1, 0, 0, 0,     1, 4'h6, 1, 0);
        // Two bits, then mid-word ALIGN re-frames onto 0101
        add(0, 1, 0, 0, 1,     0, 4'h6, 1, 0);
        add(0, 1, 0, 0, 1,     0, 4'h6, 1, 0);
        add(0, 1, 1, 0, 0,     0, 4'h6, 1, 1);
        add(0, 1, 0, 0, 1,     0, 4'h6, 1, 0);
        add(0, 1, 0, 0, 0,     0, 4'h6, 1, 0);
        add(0, 1, 0, 0, 1,     1, 4'h5, 1, 0);
        // 1011 with EN gaps and one slipped junk bit
        add(0, 1, 0, 0, 1,     0, 4'h5, 1, 0);
        add(0, 0, 0, 0, 0,     0, 4'h5, 1, 0);
        add(0, 1, 0, 0, 0,     0, 4'h5, 1, 0);
        add(0, 0, 0, 1, 0,     0, 4'h5, 1, 0);
        add(0, 1, 0, 1, 0,     0, 4'h5, 1, 0);
        add(0, 1, 0, 0, 1,     0, 4'h5, 1, 0);
        add(0, 0, 0, 0, 0,     0, 4'h5, 1, 0);
        add(0, 1, 0, 0, 1,     1, 4'hB, 1, 0);
        // ALIGN on a word boundary: no error
        add(0, 1, 1, 0, 0,     0, 4'hB, 1, 0);
        add(0, 1, 0, 0, 1,     0, 4'hB, 1, 0);
        add(0, 1, 0, 0, 1,     0, 4'hB, 1, 0);
        add(0, 1, 0, 0, 0,     1, 4'h6, 1, 0);
        // Reset after two bits; unaligned bits afterwards are ignored
        add(0, 1, 0, 0, 1,     0, 4'h6, 1, 0);
        add(0, 1, 0, 0, 0,     0, 4'h6, 1, 0);
        add(1, 1, 1, 0, 1,     0, 4'h0, 0, 0);
        add(0, 1, 0, 0, 1,     0, 4'h0, 0, 0);
        add(0, 1, 0, 0, 0,     0, 4'h0, 0, 0);
        add(0, 1, 0, 1, 1,     0, 4'h0, 0, 0);
        add(0, 1, 0, 0, 1,     0, 4'h0, 0, 0);
        add(0, 1, 0, 0, 1,     0, 4'h0, 0, 0);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].align, vecs[i].slip, vecs[i].sin);
            chk("par_out",   i, {4'h0, par4},   {4'h0, vecs[i].par});
            chk("par_valid", i, {7'h0, valid4}, {7'h0, vecs[i].valid});
            chk("locked",    i, {7'h0, locked4}, {7'h0, vecs[i].locked});
            chk("align_err", i, {7'h0, err4},   {7'h0, vecs[i].err});
            $display("step %0d: rst=%0b en=%0b al=%0b sl=%0b si=%0b -> par=%h v=%0b lk=%0b er=%0b",
                     i, vecs[i].rst, vecs[i].en, vecs[i].align, vecs[i].slip, vecs[i].sin,
                     par4, valid4, locked4, err4);
        end

        // 8-bit LSB-first word: 1,1,1,1,0,1,0,1 -> 8'b1010_1111
        drive(1, 0, 0, 0, 0);
        chk("w8_reset_par", 100, par8, 8'h00);
        chk("w8_reset_lock", 100, {7'h0, locked8}, 8'h00);
        bits8 = 8'b1010_1111;
        for (int b = 0; b < 8; b++) begin
            drive(0, 1, (b == 0), 0, bits8[b]);
            chk("w8_valid", 101 + b, {7'h0, valid8}, (b == 7) ? 8'h01 : 8'h00);
            chk("w8_par", 101 + b, par8, (b == 7) ? 8'hAF : 8'h00);
            $display("w8 bit %0d: si=%0b -> par=%h v=%0b lk=%0b", b, bits8[b], par8, valid8, locked8);
        end
        // Paused cycle after completion: pulse ends, word holds
        drive(0, 0, 0, 0, 0);
        chk("w8_hold_valid", 109, {7'h0, valid8}, 8'h00);
        chk("w8_hold_par", 109, par8, 8'hAF);
        chk("w8_hold_lock", 109, {7'h0, locked8}, 8'h01);
        $display("w8 hold: par=%h v=%0b lk=%0b", par8, valid8, locked8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
